// File: rtl/pipe_hazard_sched_if.sv
// Decode/hazard signal bundle between the ID/EX pipeline and pipe_hazard_sched.
// master = pipeline side (drives decode fields), slave = scheduler side.
interface pipe_hazard_sched_if;
  logic [5:0] id_op;
  logic [5:0] id_funct;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] ex_rw;
  logic       ex_mem_read;
  logic       b_result;
  logic       pc_if_wr;
  logic       id_ex_bubble;
  logic       if_id_flush;
  logic       md_start;
  logic       md_busy;
  logic       md_done;

  modport master (
    output id_op, id_funct, id_rs, id_rt, ex_rw, ex_mem_read, b_result,
    input  pc_if_wr, id_ex_bubble, if_id_flush, md_start, md_busy, md_done
  );

  modport slave (
    input  id_op, id_funct, id_rs, id_rt, ex_rw, ex_mem_read, b_result,
    output pc_if_wr, id_ex_bubble, if_id_flush, md_start, md_busy, md_done
  );
endinterface

// File: rtl/pipe_hazard_sched.sv
// Hazard scheduler for the 5-stage MIPS pipeline: load-use and HI/LO stalls,
// ID-resolved flushes, and the MD busy counter. Optional macro HAZARD_STATS_EN adds stall/flush counters.
module pipe_hazard_sched #(
  parameter int unsigned MD_LATENCY = 8,
  parameter int unsigned CNT_W      = 5
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_sched_if.slave hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [15:0]        flush_count
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_JALR   = 6'h09;
  localparam logic [5:0] F_MFHI   = 6'h10;
  localparam logic [5:0] F_MTHI   = 6'h11;
  localparam logic [5:0] F_MFLO   = 6'h12;
  localparam logic [5:0] F_MTLO   = 6'h13;
  localparam logic [5:0] F_MULT   = 6'h18;
  localparam logic [5:0] F_MULTU  = 6'h19;
  localparam logic [5:0] F_DIV    = 6'h1A;
  localparam logic [5:0] F_DIVU   = 6'h1B;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic dec_beq, dec_jump, dec_hilo, dec_md;
  logic lu, hl, stall, flush_req, issue, busy_int;

  // Case-based decode: an unknown opcode/funct falls into default and raises nothing.
  always_comb begin
    dec_beq  = 1'b0;
    dec_jump = 1'b0;
    dec_hilo = 1'b0;
    dec_md   = 1'b0;
    case (hz.id_op)
      OP_RTYPE: begin
        case (hz.id_funct)
          F_JR, F_JALR:                      dec_jump = 1'b1;
          F_MFHI, F_MTHI, F_MFLO, F_MTLO:    dec_hilo = 1'b1;
          F_MULT, F_MULTU, F_DIV, F_DIVU:    dec_md   = 1'b1;
          default: ;
        endcase
      end
      OP_J, OP_JAL: dec_jump = 1'b1;
      OP_BEQ:       dec_beq  = 1'b1;
      default: ;
    endcase
  end

  assign busy_int  = (cnt_q != '0);
  assign lu        = hz.ex_mem_read && (hz.ex_rw != 5'd0) &&
                     ((hz.id_rs == hz.ex_rw) || (hz.id_rt == hz.ex_rw));
  assign hl        = busy_int && (dec_hilo || dec_md);
  assign stall     = lu || hl;
  assign flush_req = dec_jump || (dec_beq && hz.b_result);
  assign issue     = !rst && !stall && dec_md;

  // Stall outranks flush so a branch never redirects on a stale operand.
  always_comb begin
    hz.pc_if_wr     = 1'b1;
    hz.id_ex_bubble = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.md_start     = 1'b0;
    hz.md_busy      = 1'b0;
    hz.md_done      = 1'b0;
    if (!rst) begin
      hz.pc_if_wr     = !stall;
      hz.id_ex_bubble = stall;
      hz.if_id_flush  = !stall && flush_req;
      hz.md_start     = issue;
      hz.md_busy      = busy_int;
      hz.md_done      = (cnt_q == CNT_W'(1));
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (issue) begin
      cnt_d = CNT_W'(MD_LATENCY);
    end else if (busy_int) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stall && (stall_cycles_q != '1)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (!stall && flush_req && (flush_count_q != '1)) begin
        flush_count_q <= flush_count_q + 16'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Directed bench for pipe_hazard_sched: each step pushes its expected control
// vector {pc_if_wr, id_ex_bubble, if_id_flush, md_start, md_busy, md_done} to a scoreboard.
module tb_pipe_hazard_sched;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] F_ADD = 6'h20, F_JR = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  localparam logic [5:0] V_RUN   = 6'b100000;
  localparam logic [5:0] V_STALL = 6'b010000;
  localparam logic [5:0] V_FLUSH = 6'b101000;
  localparam logic [5:0] V_START = 6'b100100;
  localparam logic [5:0] V_BUSY  = 6'b100010;
  localparam logic [5:0] V_LAST  = 6'b100011;
  localparam logic [5:0] V_HLST  = 6'b010010;
  localparam logic [5:0] V_HLDN  = 6'b010011;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  int   st_exp = 0;
  int   fl_exp = 0;
  sb_t  sb[$];

  pipe_hazard_sched_if hz_if ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [15:0] flush_count;
  pipe_hazard_sched #(.MD_LATENCY(8), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .hz(hz_if),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );
`else
  pipe_hazard_sched #(.MD_LATENCY(8), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .hz(hz_if)
  );
`endif

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200us");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input string tag, input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rw,
                      input logic mr, input logic br, input logic [5:0] exp_v);
    sb_t        e;
    logic [5:0] obs;
    @(negedge clk);
    rst               = r;
    hz_if.id_op       = op;
    hz_if.id_funct    = fn;
    hz_if.id_rs       = rs;
    hz_if.id_rt       = rt;
    hz_if.ex_rw       = rw;
    hz_if.ex_mem_read = mr;
    hz_if.b_result    = br;
    sb.push_back('{tag, exp_v});
    if (r) begin
      st_exp = 0;
      fl_exp = 0;
    end else begin
      if (exp_v[4]) st_exp++;
      if (exp_v[3]) fl_exp++;
    end
    #1;
    e   = sb.pop_front();
    obs = {hz_if.pc_if_wr, hz_if.id_ex_bubble, hz_if.if_id_flush,
           hz_if.md_start, hz_if.md_busy, hz_if.md_done};
    compared++;
    assert (obs === e.val) else begin
      mismatched++;
      $error("FAIL %s: got %b want %b", e.tag, obs, e.val);
    end
    $display("step %-10s rst=%0b op=%h fn=%h rs=%0d rt=%0d rw=%0d mr=%0b br=%0b -> %b",
             tag, r, op, fn, rs, rt, rw, mr, br, obs);
  endtask

  task automatic rop(input string tag, input logic [5:0] fn, input logic [5:0] exp_v);
    step(tag, 1'b0, OP_R, fn, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, exp_v);
  endtask

  initial begin
    hz_if.id_op = OP_R; hz_if.id_funct = F_ADD; hz_if.id_rs = 5'd1; hz_if.id_rt = 5'd2;
    hz_if.ex_rw = 5'd0; hz_if.ex_mem_read = 1'b0; hz_if.b_result = 1'b0;

    step("reset", 1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, V_RUN);
    rop("idle", F_ADD, V_RUN);

    // Load-use
    step("lu_rs",   1'b0, OP_R, F_ADD, 5'd5, 5'd2, 5'd5, 1'b1, 1'b0, V_STALL);
    step("lu_rt",   1'b0, OP_R, F_ADD, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, V_STALL);
    step("lu_r0",   1'b0, OP_R, F_ADD, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, V_RUN);
    step("lu_nomat",1'b0, OP_R, F_ADD, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, V_RUN);

    // Branch behind load, then control flow
    step("beq_lu",  1'b0, OP_BEQ, 6'h00, 5'd5, 5'd6, 5'd5, 1'b1, 1'b1, V_STALL);
    step("beq_go",  1'b0, OP_BEQ, 6'h00, 5'd5, 5'd6, 5'd5, 1'b0, 1'b1, V_FLUSH);
    step("beq_nt",  1'b0, OP_BEQ, 6'h00, 5'd5, 5'd6, 5'd5, 1'b0, 1'b0, V_RUN);
    step("j",       1'b0, OP_J,   6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, V_FLUSH);
    step("jal",     1'b0, OP_JAL, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, V_FLUSH);
    rop("jr",   F_JR,   V_FLUSH);
    rop("jalr", F_JALR, V_FLUSH);

    // MULT then MFLO stalls through the whole busy window
    rop("mult", F_MULT, V_START);
    for (int i = 0; i < 8; i++) rop("mflo_st", F_MFLO, (i == 7) ? V_HLDN : V_HLST);
    rop("mflo_go", F_MFLO, V_RUN);

    // DIV then DIVU back to back; ADD and J flow during busy
    rop("div", F_DIV, V_START);
    for (int i = 0; i < 8; i++) rop("divu_st", F_DIVU, (i == 7) ? V_HLDN : V_HLST);
    rop("divu", F_DIVU, V_START);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) step("j_busy", 1'b0, OP_J, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 6'b101010);
      else rop("add_busy", F_ADD, (i == 7) ? V_LAST : V_BUSY);
    end
    rop("add_idle", F_ADD, V_RUN);

    // HI/LO accessors stall, then reset lands at cnt=3
    rop("mult2", F_MULT, V_START);
    rop("mthi_st", F_MTHI, V_HLST);
    rop("mfhi_st", F_MFHI, V_HLST);
    rop("mtlo_st", F_MTLO, V_HLST);
    rop("add_b5", F_ADD, V_BUSY);
    rop("add_b4", F_ADD, V_BUSY);
    step("rst_mid",  1'b1, OP_R, F_ADD, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, V_RUN);
    step("rst_mult", 1'b1, OP_R, F_MULT, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, V_RUN);
    for (int i = 0; i < 4; i++) rop("post_rst", F_ADD, V_RUN);
    rop("mult3", F_MULT, V_START);
    rop("add_b8", F_ADD, V_BUSY);

`ifdef HAZARD_STATS_EN
    @(negedge clk);
    compared++;
    assert (stall_cycles === 32'(st_exp)) else begin
      mismatched++;
      $error("FAIL stall_cycles: got %0d want %0d", stall_cycles, st_exp);
    end
    compared++;
    assert (flush_count === 16'(fl_exp)) else begin
      mismatched++;
      $error("FAIL flush_count: got %0d want %0d", flush_count, fl_exp);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
